// File: rtl/mem_bus_ctrl_pkg.sv
// Shared bus definitions for the miniRV memory path.
// bus_state_e is also decoded by the core's stall logic, so the encodings here
// must not change without updating the core.
package mem_bus_ctrl_pkg;

  localparam int BUS_STATE_W = 2;

  typedef enum logic [BUS_STATE_W-1:0] {
    BUS_IDLE      = 2'd0,
    BUS_WAIT_INST = 2'd1,
    BUS_WAIT_LOAD = 2'd2
  } bus_state_e;

endpackage

// File: rtl/mem_bus_ctrl_lat_cnt.sv
// Read-latency counter.
// Ports:
//   clock, reset : clock, synchronous active-high reset
//   load_i       : reload with RAM_LAT-1 (a read is being issued)
//   clr_i        : force to zero (in-flight read aborted)
//   en_i         : decrement while nonzero (a read is in flight)
//   zero_o       : counter is zero; read data is on the RAM bus this cycle
module mem_bus_ctrl_lat_cnt #(
  parameter int RAM_LAT = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic load_i,
  input  logic clr_i,
  input  logic en_i,
  output logic zero_o
);

  localparam int CW = $clog2(RAM_LAT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                        cnt_d = '0;
    else if (load_i)                  cnt_d = CW'(RAM_LAT - 1);
    else if (en_i && cnt_q != '0)     cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Single-port RAM bus controller: loader writes, core data accesses and
// instruction fetch share one RAM port with fixed read latency.
// Ports:
//   clock, reset              : clock, synchronous active-high reset
//   top_mem_*                 : loader write port (highest priority, aborts reads)
//   if_req/if_addr            : fetch request, held until if_rvalid
//   if_rvalid/if_rdata        : one-cycle fetch response pulse + held data
//   d_req/d_wen/d_addr/...    : data request, held until d_done
//   d_done/d_rdata            : one-cycle store ack / load response + held data
//   ram_*                     : RAM port (ram_rdata valid RAM_LAT cycles after ram_ren)
//   bus_state                 : current bus_state_e, used by the core to stall
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RAM_LAT = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   top_mem_wen,
  input  logic [XLEN-1:0]        top_mem_addr,
  input  logic [XLEN-1:0]        top_mem_wdata,
  input  logic                   if_req,
  input  logic [XLEN-1:0]        if_addr,
  output logic                   if_rvalid,
  output logic [XLEN-1:0]        if_rdata,
  input  logic                   d_req,
  input  logic                   d_wen,
  input  logic [XLEN-1:0]        d_addr,
  input  logic [XLEN-1:0]        d_wdata,
  input  logic [3:0]             d_wbmask,
  output logic                   d_done,
  output logic [XLEN-1:0]        d_rdata,
  output logic                   ram_wen,
  output logic                   ram_ren,
  output logic [XLEN-1:0]        ram_addr,
  output logic [XLEN-1:0]        ram_wdata,
  output logic [3:0]             ram_wbmask,
  input  logic [XLEN-1:0]        ram_rdata,
  output logic [BUS_STATE_W-1:0] bus_state
);

  bus_state_e state_q, state_d;

  logic            cnt_zero;
  logic            issue, st_ack, abort, cap_inst, cap_load;
  logic            if_rvalid_q, d_done_q;
  logic [XLEN-1:0] if_rdata_q, d_rdata_q;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= BUS_IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BUS_IDLE: begin
        if (top_mem_wen)          state_d = BUS_IDLE;
        else if (d_req && d_wen)  state_d = BUS_IDLE;
        else if (d_req)           state_d = BUS_WAIT_LOAD;
        else if (if_req)          state_d = BUS_WAIT_INST;
      end
      BUS_WAIT_INST, BUS_WAIT_LOAD: begin
        // Loader write wins even mid-read; the late RAM data is dropped.
        if (top_mem_wen || cnt_zero) state_d = BUS_IDLE;
      end
      default: state_d = BUS_IDLE;
    endcase
  end

  // Outputs: grant, RAM strobes and capture enables. Gated in reset so the
  // RAM sees no access while the controller is being cleared.
  always_comb begin
    ram_wen    = 1'b0;
    ram_ren    = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    ram_wbmask = '0;
    issue      = 1'b0;
    st_ack     = 1'b0;
    abort      = 1'b0;
    cap_inst   = 1'b0;
    cap_load   = 1'b0;
    if (!reset) begin
      if (top_mem_wen) begin
        ram_wen    = 1'b1;
        ram_addr   = top_mem_addr;
        ram_wdata  = top_mem_wdata;
        ram_wbmask = 4'hF;
        abort      = (state_q != BUS_IDLE);
      end else if (state_q == BUS_IDLE) begin
        if (d_req && d_wen) begin
          ram_wen    = 1'b1;
          ram_addr   = d_addr;
          ram_wdata  = d_wdata;
          ram_wbmask = d_wbmask;
          st_ack     = 1'b1;
        end else if (d_req) begin
          ram_ren  = 1'b1;
          ram_addr = d_addr;
          issue    = 1'b1;
        end else if (if_req) begin
          ram_ren  = 1'b1;
          ram_addr = if_addr;
          issue    = 1'b1;
        end
      end else if (cnt_zero) begin
        cap_inst = (state_q == BUS_WAIT_INST);
        cap_load = (state_q == BUS_WAIT_LOAD);
      end
    end
  end

  mem_bus_ctrl_lat_cnt #(.RAM_LAT(RAM_LAT)) u_lat_cnt (
    .clock  (clock),
    .reset  (reset),
    .load_i (issue),
    .clr_i  (abort),
    .en_i   (state_q != BUS_IDLE),
    .zero_o (cnt_zero)
  );

  // Response registers: pulses last one cycle, data holds between pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      if_rvalid_q <= 1'b0;
      d_done_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= cap_inst;
      d_done_q    <= cap_load | st_ack;
      if (cap_inst) if_rdata_q <= ram_rdata;
      if (cap_load) d_rdata_q  <= ram_rdata;
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_done    = d_done_q;
  assign d_rdata   = d_rdata_q;
  assign bus_state = state_q;

endmodule
